// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: memory opcodes, the NOP bundle and the
// memory-stage state encoding.
package cpu_pkg;

    localparam logic [5:0]  OP_LOAD    = 6'b010000;
    localparam logic [5:0]  OP_STORE   = 6'b010001;
    localparam logic [31:0] NOP_SLOT   = {3'b111, 29'b0};
    localparam logic [63:0] NOP_BUNDLE = {NOP_SLOT, NOP_SLOT};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_lat_ctr.sv
// Down-counter covering the BRAM read latency; done marks the last WAIT
// cycle so the FSM enters DONE exactly when douta becomes valid.
module mem_lat_ctr #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic done
);

    localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(RD_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one 64-bit data-BRAM load/store per bundle, stalls
// upstream while a load waits out RD_LAT. Optional MEM_STORE_FWD_EN adds a
// 1-entry store-to-load forwarding register.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [63:0]       inst,
    input  logic              ex_to_mem_ready,
    input  logic [31:0]       u_tdata,
    input  logic [31:0]       l_tdata,
    input  logic [4:0]        u_rt,
    input  logic [4:0]        l_rt,
    input  logic              u_rt_flag,
    input  logic              l_rt_flag,
    input  logic [63:0]       dina,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] addra,
    output logic [7:0]        wea,
    input  logic [63:0]       douta,
    output logic [63:0]       dina_mem,
    output logic [63:0]       inst_to_the_next,
    output logic [31:0]       u_wdata,
    output logic [31:0]       l_wdata,
    output logic [4:0]        u_rt_to_the_next,
    output logic [4:0]        l_rt_to_the_next,
    output logic              u_rt_flag_to_the_next,
    output logic              l_rt_flag_to_the_next
);

    mem_state_t        state, state_nxt;
    logic              is_load, is_store, lo_load, load_req;
    logic              fwd_hit, ctr_load, ctr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       fwd_data, ld_word;

    logic [63:0] inst_n;
    logic [31:0] u_wd_n, l_wd_n;
    logic [4:0]  u_rt_n, l_rt_n;
    logic        u_f_n, l_f_n;

    assign is_load  = (inst[63:58] == OP_LOAD);
    assign is_store = (inst[63:58] == OP_STORE);
    assign lo_load  = (inst[31:26] == OP_LOAD);
    assign load_req = is_load || ex_to_mem_ready;
    assign mem_addr = u_tdata[ADDR_W-1:0];

    assign addra    = mem_addr;
    assign dina_mem = dina;
    assign ctr_load = (state == IDLE) && load_req && !fwd_hit;

`ifdef MEM_STORE_FWD_EN
    logic              fwd_vld;
    logic [ADDR_W-1:0] fwd_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else if (state == IDLE && is_store && !load_req) begin
            fwd_vld  <= 1'b1;
            fwd_addr <= mem_addr;
            fwd_data <= dina;
        end
    end

    assign fwd_hit = (state == IDLE) && load_req && fwd_vld && (fwd_addr == mem_addr);
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    mem_lat_ctr #(.RD_LAT(RD_LAT)) u_lat_ctr (
        .clk  (clk),
        .rstn (rstn),
        .load (ctr_load),
        .done (ctr_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctr_load) state_nxt = (RD_LAT == 1) ? DONE : WAIT;
            WAIT:    if (ctr_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall is gated by rstn so it drops the moment reset hits a pending load.
    always_comb begin
        mem_stall = rstn && (ctr_load || state == WAIT);
        wea       = (rstn && state == IDLE && is_store && !load_req) ? 8'hFF : 8'h00;
        ld_word   = (state == DONE) ? douta : fwd_data;
        inst_n    = NOP_BUNDLE;
        u_wd_n    = '0;
        l_wd_n    = '0;
        u_rt_n    = '0;
        l_rt_n    = '0;
        u_f_n     = 1'b0;
        l_f_n     = 1'b0;
        if ((state == IDLE && !ctr_load) || state == DONE) begin
            inst_n = inst;
            u_rt_n = u_rt;
            l_rt_n = l_rt;
            u_f_n  = u_rt_flag;
            l_f_n  = l_rt_flag;
            if (state == DONE || fwd_hit) begin
                u_wd_n = ld_word[63:32];
                l_wd_n = lo_load ? ld_word[31:0] : l_tdata;
            end else begin
                u_wd_n = u_tdata;
                l_wd_n = l_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_to_the_next      <= NOP_BUNDLE;
            u_wdata               <= '0;
            l_wdata               <= '0;
            u_rt_to_the_next      <= '0;
            l_rt_to_the_next      <= '0;
            u_rt_flag_to_the_next <= 1'b0;
            l_rt_flag_to_the_next <= 1'b0;
        end else begin
            inst_to_the_next      <= inst_n;
            u_wdata               <= u_wd_n;
            l_wdata               <= l_wd_n;
            u_rt_to_the_next      <= u_rt_n;
            l_rt_to_the_next      <= l_rt_n;
            u_rt_flag_to_the_next <= u_f_n;
            l_rt_flag_to_the_next <= l_f_n;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a 2-cycle BRAM model; the forwarding
// vector runs only when MEM_STORE_FWD_EN is defined.
module tb_mem_stage;
    import cpu_pkg::*;

    localparam int ADDR_W = 15;
    localparam int RD_LAT = 2;
    localparam logic [5:0] OP_ALU = 6'b000001;

    logic              clk = 1'b0;
    logic              rstn;
    logic [63:0]       inst;
    logic              ex_to_mem_ready;
    logic [31:0]       u_tdata, l_tdata;
    logic [4:0]        u_rt, l_rt;
    logic              u_rt_flag, l_rt_flag;
    logic [63:0]       dina;
    logic              mem_stall;
    logic [ADDR_W-1:0] addra;
    logic [7:0]        wea;
    logic [63:0]       douta;
    logic [63:0]       dina_mem;
    logic [63:0]       inst_to_the_next;
    logic [31:0]       u_wdata, l_wdata;
    logic [4:0]        u_rt_to_the_next, l_rt_to_the_next;
    logic              u_rt_flag_to_the_next, l_rt_flag_to_the_next;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] bram [0:255];
    logic [7:0]  rd_a1;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .inst                  (inst),
        .ex_to_mem_ready       (ex_to_mem_ready),
        .u_tdata               (u_tdata),
        .l_tdata               (l_tdata),
        .u_rt                  (u_rt),
        .l_rt                  (l_rt),
        .u_rt_flag             (u_rt_flag),
        .l_rt_flag             (l_rt_flag),
        .dina                  (dina),
        .mem_stall             (mem_stall),
        .addra                 (addra),
        .wea                   (wea),
        .douta                 (douta),
        .dina_mem              (dina_mem),
        .inst_to_the_next      (inst_to_the_next),
        .u_wdata               (u_wdata),
        .l_wdata               (l_wdata),
        .u_rt_to_the_next      (u_rt_to_the_next),
        .l_rt_to_the_next      (l_rt_to_the_next),
        .u_rt_flag_to_the_next (u_rt_flag_to_the_next),
        .l_rt_flag_to_the_next (l_rt_flag_to_the_next)
    );

    // BRAM model: address registered, then data registered (2-cycle read).
    always @(posedge clk) begin
        if (wea == 8'hFF) bram[addra[7:0]] <= dina_mem;
        rd_a1 <= addra[7:0];
        douta <= bram[rd_a1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [5:0] op_u, input logic [5:0] op_l);
        return {op_u, 26'h0000123, op_l, 26'h0000456};
    endfunction

    task automatic drive(input logic [63:0] b, input logic [31:0] ut, input logic [4:0] urt,
                         input logic uf, input logic [31:0] lt, input logic [4:0] lrt,
                         input logic lf, input logic [63:0] d, input logic rdy);
        inst = b; u_tdata = ut; u_rt = urt; u_rt_flag = uf;
        l_tdata = lt; l_rt = lrt; l_rt_flag = lf; dina = d; ex_to_mem_ready = rdy;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [63:0] st_a, st_b, ld_p, ld1, ld2, st_c, alu;
    logic [63:0] exp_seq [0:6];

    initial begin
        for (int i = 0; i < 256; i++) bram[i] = '0;
        rd_a1 = '0;
        douta = '0;
        alu  = mk(OP_ALU, OP_ALU);
        st_a = mk(OP_STORE, OP_ALU);
        st_b = mk(OP_STORE, 6'b000010);
        ld_p = mk(OP_LOAD, OP_LOAD);
        ld1  = mk(OP_LOAD, OP_ALU);
        ld2  = mk(6'b000011, OP_ALU);
        st_c = mk(OP_STORE, 6'b000100);
        exp_seq = '{NOP_BUNDLE, NOP_BUNDLE, ld1, NOP_BUNDLE, NOP_BUNDLE, ld2, st_c};

        rstn = 1'b0;
        drive(NOP_BUNDLE, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_inst", inst_to_the_next, NOP_BUNDLE);
        check("rst_uflag", u_rt_flag_to_the_next, 0);
        check("rst_lflag", l_rt_flag_to_the_next, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wea", wea, 0);
        check("rst_uwdata", u_wdata, 0);
        rstn = 1'b1;

        // 1: ALU pass-through
        drive(alu, 32'd5, 5'd3, 1, 32'd7, 5'd4, 1, 0, 0);
        #1 check("alu_stall0", mem_stall, 0);
        tick();
        check("alu_uwdata", u_wdata, 32'd5);
        check("alu_urt", u_rt_to_the_next, 5'd3);
        check("alu_uflag", u_rt_flag_to_the_next, 1);
        check("alu_lwdata", l_wdata, 32'd7);
        check("alu_stall1", mem_stall, 0);

        // 2: stores, first one wraps the address
        drive(st_a, 32'h0000_8011, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 0);
        #1 check("stw_wea", wea, 8'hFF);
        check("stw_addr", addra, 15'h0011);
        check("stw_din", dina_mem, 64'h1111_2222_3333_4444);
        tick();
        check("stw_inst", inst_to_the_next, st_a);
        check("stw_flag", u_rt_flag_to_the_next, 0);
        drive(st_b, 32'h10, 0, 0, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 0);
        #1 check("st_wea", wea, 8'hFF);
        check("st_addr", addra, 15'h0010);
        check("st_stall", mem_stall, 0);
        tick();
        drive(st_a, 32'h55, 0, 0, 0, 0, 0, 64'h0, 0);
        tick();

        // 3: paired load from 0x10
        drive(ld_p, 32'h10, 5'd7, 1, 32'h99, 5'd8, 1, 0, 0);
        #1 check("pl_stall_c0", mem_stall, 1);
        check("pl_addr", addra, 15'h0010);
        check("pl_wea", wea, 0);
        tick();
        check("pl_stall_c1", mem_stall, 1);
        check("pl_wait_flag", u_rt_flag_to_the_next, 0);
        check("pl_wait_inst", inst_to_the_next, NOP_BUNDLE);
        tick();
        check("pl_stall_c2", mem_stall, 0);
        check("pl_done_flag", u_rt_flag_to_the_next, 0);
        tick();
        check("pl_uwdata", u_wdata, 32'hDEADBEEF);
        check("pl_lwdata", l_wdata, 32'h01234567);
        check("pl_urt", u_rt_to_the_next, 5'd7);
        check("pl_lrt", l_rt_to_the_next, 5'd8);
        check("pl_lflag", l_rt_flag_to_the_next, 1);
        check("pl_inst", inst_to_the_next, ld_p);

        // 4: LOAD, LOAD (via ex_to_mem_ready), STORE back-to-back
        drive(ld1, 32'h11, 5'd9, 1, 32'hAB, 5'd10, 1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("seq_inst%0d", k), inst_to_the_next, exp_seq[k]);
            if (k == 2) begin
                check("seq_l1_u", u_wdata, 32'h11112222);
                check("seq_l1_l", l_wdata, 32'hAB);
                drive(ld2, 32'h10, 5'd11, 1, 32'hCD, 5'd12, 1, 0, 1);
            end
            if (k == 5) begin
                check("seq_l2_u", u_wdata, 32'hDEADBEEF);
                check("seq_l2_l", l_wdata, 32'hCD);
                drive(st_c, 32'h30, 0, 0, 0, 0, 0, 64'h5555_6666_7777_8888, 0);
            end
        end

        // 5: reset while waiting on a load
        drive(ld1, 32'h12, 5'd13, 1, 32'h1, 5'd14, 1, 0, 0);
        tick();
        check("rw_stall_wait", mem_stall, 1);
        rstn = 1'b0;
        #1 check("rw_stall", mem_stall, 0);
        check("rw_uflag", u_rt_flag_to_the_next, 0);
        check("rw_inst", inst_to_the_next, NOP_BUNDLE);
        drive(alu, 32'd5, 5'd3, 1, 32'd7, 5'd4, 1, 0, 0);
        tick();
        rstn = 1'b1;
        tick();
        check("rw_alu_uwdata", u_wdata, 32'd5);
        check("rw_alu_uflag", u_rt_flag_to_the_next, 1);
        check("rw_alu_stall", mem_stall, 0);

`ifdef MEM_STORE_FWD_EN
        // 6: store then load of the same address is forwarded
        drive(st_a, 32'h20, 0, 0, 0, 0, 0, 64'hCAFE_F00D_8BAD_F00D, 0);
        tick();
        drive(ld_p, 32'h20, 5'd15, 1, 32'h2, 5'd16, 1, 0, 0);
        #1 check("fwd_stall", mem_stall, 0);
        tick();
        check("fwd_uwdata", u_wdata, 32'hCAFEF00D);
        check("fwd_lwdata", l_wdata, 32'h8BADF00D);
        check("fwd_uflag", u_rt_flag_to_the_next, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
